vproc_bus_responder: RTL and testbench

VPROC_BUS_RESPONDER -- requirements
Module: vproc_bus_responder

---
 rtl/vproc_resp_pkg.sv | 16 +
 rtl/vproc_resp_mem.sv | 34 +++
 rtl/vproc_bus_responder.sv | 155 +++++++++++++++
 tb/tb_vproc_bus_responder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/vproc_resp_pkg.sv
// Shared types and widths for the vproc bus responder: FSM states,
// wait-counter width, data and byte-enable widths.
package vproc_resp_pkg;

  localparam int CNT_W  = 4;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/vproc_resp_mem.sv
// Byte-enabled single-write/single-read memory. Each byte lane is its own
// array with a registered read so it maps onto block RAM.
module vproc_resp_mem
  import vproc_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [BE_W-1:0]       be,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  genvar gi;
  for (gi = 0; gi < BE_W; gi++) begin : g_lane
    logic [BYTE_W-1:0] lane_mem [DEPTH];
    logic [BYTE_W-1:0] lane_rd_q;

    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        lane_mem[wr_addr] <= wr_data[gi*BYTE_W +: BYTE_W];
      end
      lane_rd_q <= lane_mem[rd_addr];
    end

    assign rd_data[gi*BYTE_W +: BYTE_W] = lane_rd_q;
  end

endmodule

// File: rtl/vproc_bus_responder.sv
// Wait-state bus responder in front of a byte-enabled memory.
// Define VPROC_RESP_ERR_EN to build the sticky protocol-error flag.
module vproc_bus_responder
  import vproc_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int RD_WAIT    = 1,
  parameter int WR_WAIT    = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       Addr,
  input  logic [BE_W-1:0]   BE,
  input  logic              WE,
  input  logic              RD,
  input  logic [DATA_W-1:0] WrData,
  input  logic              Stall,
  output logic [DATA_W-1:0] RdData,
  output logic              WRAck,
  output logic              RDAck,
  output logic              ErrFlag
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BE_W-1:0]         be_q, be_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    is_wr_q, is_wr_d;
  logic                    wr_ack_q, wr_ack_d;
  logic                    rd_ack_q, rd_ack_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_rd_addr;
  logic [DATA_W-1:0]       mem_rd_data;

  // Upper address bits alias onto the memory and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, Addr[31:ADDR_WIDTH]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    wr_ack_d    = 1'b0;
    rd_ack_d    = 1'b0;
    rdata_d     = rdata_q;
    mem_we      = 1'b0;
    mem_rd_addr = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        // Read the live address so the word is ready even with zero wait.
        mem_rd_addr = Addr[ADDR_WIDTH-1:0];
        if (RD || WE) begin
          addr_d  = Addr[ADDR_WIDTH-1:0];
          be_d    = BE;
          wdata_d = WrData;
          is_wr_d = WE;
          cnt_d   = WE ? CNT_W'(WR_WAIT) : CNT_W'(RD_WAIT);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if ((cnt_q != '0) || Stall) begin
          cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        end else begin
          state_d = ST_ACK;
          if (is_wr_q) begin
            wr_ack_d = 1'b1;
            mem_we   = 1'b1;
          end else begin
            rd_ack_d = 1'b1;
            rdata_d  = mem_rd_data;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ack_q <= wr_ack_d;
      rd_ack_q <= rd_ack_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge Clk) begin
    addr_q  <= addr_d;
    be_q    <= be_d;
    wdata_q <= wdata_d;
    is_wr_q <= is_wr_d;
  end

  // A reset on the completing edge must not let the write through.
  vproc_resp_mem #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk    (Clk),
    .we     (mem_we && !Reset),
    .be     (be_q),
    .wr_addr(addr_q),
    .wr_data(wdata_q),
    .rd_addr(mem_rd_addr),
    .rd_data(mem_rd_data)
  );

`ifdef VPROC_RESP_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((state_q == ST_IDLE) && RD && WE) begin
      err_d = 1'b1;
    end
    if ((state_q == ST_WAIT) && (is_wr_q ? !WE : !RD)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ErrFlag = err_q;
`else
  assign ErrFlag = 1'b0;
`endif

  assign RdData = rdata_q;
  assign WRAck  = wr_ack_q;
  assign RDAck  = rd_ack_q;

endmodule

// File: tb/tb_vproc_bus_responder.sv
// Directed bench for vproc_bus_responder (RD_WAIT=1, WR_WAIT=0); latency is
// counted with the cycle after the sampling edge as cycle 1.
module tb_vproc_bus_responder;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Addr = '0;
  logic [3:0]  BE = '0;
  logic        WE = 1'b0;
  logic        RD = 1'b0;
  logic [31:0] WrData = '0;
  logic        Stall = 1'b0;
  logic [31:0] RdData;
  logic        WRAck;
  logic        RDAck;
  logic        ErrFlag;

  int errors = 0;
  int checks = 0;

  vproc_bus_responder #(
    .ADDR_WIDTH(10),
    .RD_WAIT   (1),
    .WR_WAIT   (0)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Addr   (Addr),
    .BE     (BE),
    .WE     (WE),
    .RD     (RD),
    .WrData (WrData),
    .Stall  (Stall),
    .RdData (RdData),
    .WRAck  (WRAck),
    .RDAck  (RDAck),
    .ErrFlag(ErrFlag)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One beat, entered #1 after a posedge and left #1 after a posedge.
  // Stall is high for the WAIT edges numbered st_start .. st_start+st_len-1.
  task automatic beat(input string tag, input bit wr, input bit rd,
                      input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                      input int st_start, input int st_len, input int exp_lat,
                      input logic [31:0] exp_rdata);
    int   lat;
    logic other;
    Addr = a; BE = be; WrData = d; WE = wr; RD = rd; Stall = 1'b0;
    @(posedge Clk); #1;
    lat = -1;
    other = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      Stall = (k >= st_start) && (k < st_start + st_len);
      @(posedge Clk); #1;
      if (wr ? RDAck : WRAck) other = 1'b1;
      if (wr ? WRAck : RDAck) begin
        lat = k + 1;
        break;
      end
    end
    Stall = 1'b0;
    $display("beat %s wr=%0d addr=0x%08h be=0x%h wdata=0x%08h lat=%0d rdata=0x%08h",
             tag, wr, a, be, d, lat, RdData);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_xack"}, {31'd0, other}, 32'd0);
    check({tag, "_rdata"}, RdData, exp_rdata);
    @(posedge Clk); #1;
    check({tag, "_pulse"}, {31'd0, (wr ? WRAck : RDAck)}, 32'd0);
    WE = 1'b0; RD = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    check("rst_rdata", RdData, 32'd0);
    check("rst_wrack", {31'd0, WRAck}, 32'd0);
    check("rst_rdack", {31'd0, RDAck}, 32'd0);
    check("rst_err", {31'd0, ErrFlag}, 32'd0);
    Reset = 1'b0;

    // Full word write then read; a write leaves RdData untouched.
    beat("wr10", 1, 0, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0, 2, 32'h0);
    beat("rd10", 0, 1, 32'h10, 4'h0, 32'h0, 0, 0, 3, 32'hDEADBEEF);
    // Partial byte enables and an all-zero enable.
    beat("wr10_be3", 1, 0, 32'h10, 4'h3, 32'h00001234, 0, 0, 2, 32'hDEADBEEF);
    beat("rd10_be3", 0, 1, 32'h10, 4'h0, 32'h0, 0, 0, 3, 32'hDEAD1234);
    beat("wr10_be0", 1, 0, 32'h10, 4'h0, 32'hFFFFFFFF, 0, 0, 2, 32'hDEAD1234);
    beat("rd10_be0", 0, 1, 32'h10, 4'h0, 32'h0, 0, 0, 3, 32'hDEAD1234);
    // Upper address bits alias onto the same word.
    beat("wr410", 1, 0, 32'h410, 4'hF, 32'hCAFEF00D, 0, 0, 2, 32'hDEAD1234);
    beat("rd10_alias", 0, 1, 32'hFFFF_F810, 4'h0, 32'h0, 0, 0, 3, 32'hCAFEF00D);
    // Burst of independent beats, each with its own address.
    for (int i = 0; i < 4; i++)
      beat($sformatf("burst_wr%0d", i), 1, 0, 32'h20 + 32'(i), 4'hF, 32'(i + 1), 0, 0, 2,
           32'hCAFEF00D);
    beat("burst_rd0", 0, 1, 32'h20, 4'h0, 32'h0, 0, 0, 3, 32'd1);
    beat("burst_rd1", 0, 1, 32'h21, 4'h0, 32'h0, 0, 0, 3, 32'd2);
    beat("burst_rd2", 0, 1, 32'h22, 4'h0, 32'h0, 0, 0, 3, 32'd3);
    beat("burst_rd3", 0, 1, 32'h23, 4'h0, 32'h0, 0, 0, 3, 32'd4);
    // Stall held for five cycles after the wait count runs out: 3 + 5.
    beat("wr05", 1, 0, 32'h5, 4'hF, 32'h55AA0055, 0, 0, 2, 32'd4);
    beat("rd05_stall", 0, 1, 32'h5, 4'h0, 32'h0, 2, 5, 8, 32'h55AA0055);

    // Reset while a write to 0x30 sits in WAIT.
    beat("wr30", 1, 0, 32'h30, 4'hF, 32'hA5A5A5A5, 0, 0, 2, 32'h55AA0055);
    Addr = 32'h30; BE = 4'hF; WrData = 32'h11111111; WE = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("rstwait_wrack0", {31'd0, WRAck}, 32'd0);
    check("rstwait_rdata", RdData, 32'd0);
    WE = 1'b0; Reset = 1'b0;
    @(posedge Clk); #1;
    check("rstwait_wrack1", {31'd0, WRAck}, 32'd0);
    $display("beat rst_in_wait addr=0x00000030 wrack=%0d", WRAck);
    beat("rd30_kept", 0, 1, 32'h30, 4'h0, 32'h0, 0, 0, 3, 32'hA5A5A5A5);

    // RD and WE together complete as a write.
    beat("wr40_both", 1, 1, 32'h40, 4'hF, 32'h77778888, 0, 0, 2, 32'hA5A5A5A5);
`ifdef VPROC_RESP_ERR_EN
    check("err_set", {31'd0, ErrFlag}, 32'd1);
`else
    check("err_tied", {31'd0, ErrFlag}, 32'd0);
`endif
    beat("rd40", 0, 1, 32'h40, 4'h0, 32'h0, 0, 0, 3, 32'h77778888);
`ifdef VPROC_RESP_ERR_EN
    check("err_sticky", {31'd0, ErrFlag}, 32'd1);
`else
    check("err_still0", {31'd0, ErrFlag}, 32'd0);
`endif
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("err_cleared", {31'd0, ErrFlag}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
